// File: rtl/avr_link_arbiter.sv
// avr_link_arbiter
//
// Brings up the FPGA-to-AVR serial link once the cclk detector reports a stable clock for
// SETTLE_CYCLES consecutive cycles, then shares the single serial TX channel between two byte
// requesters using round-robin arbitration, one byte per grant. Losing cclk_ready at any time
// drops the link back to offline.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   cclk_ready stable-cclk indication (synchronous to clk)
//   req        per-requester byte request, held until granted
//   req_data0  byte from requester 0
//   req_data1  byte from requester 1
//   tx_busy    serial TX core busy
//   gnt        one-hot, one-cycle grant pulse
//   tx_data    byte to the TX core, valid with tx_new
//   tx_new     one-cycle strobe to the TX core
//   link_up    link usable (idle, sending or holding)
module avr_link_arbiter #(
  parameter int unsigned CLK_RATE      = 50000000,
  parameter int unsigned SETTLE_CYCLES = CLK_RATE / 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cclk_ready,
  input  logic [1:0] req,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  input  logic       tx_busy,
  output logic [1:0] gnt,
  output logic [7:0] tx_data,
  output logic       tx_new,
  output logic       link_up
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    StOffline,
    StSettle,
    StIdle,
    StSend,
    StHold
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ptr_q, ptr_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            win;

  // Winner index. With both requesting, the one that did not win last time goes next.
  always_comb begin
    win = 1'b0;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = ~ptr_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    tx_data_d = tx_data_q;

    unique case (state_q)
      StOffline: begin
        cnt_d = '0;
        if (cclk_ready) state_d = StSettle;
      end
      StSettle: begin
        // Stops at SETTLE_CYCLES on leaving, which the counter width still holds.
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) state_d = StIdle;
      end
      StIdle: begin
        if (cclk_ready && !tx_busy && (req != 2'b00)) begin
          ptr_d     = win;
          tx_data_d = win ? req_data1 : req_data0;
          state_d   = StSend;
        end
      end
      StSend:  state_d = StHold;
      // Dead cycle gives the TX core time to raise tx_busy.
      StHold:  state_d = StIdle;
      default: state_d = StOffline;
    endcase

    // Losing the cclk overrides every other transition.
    if (!cclk_ready) begin
      state_d = StOffline;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StOffline;
      cnt_q     <= '0;
      ptr_q     <= 1'b1;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Outputs decode the registered state only, so the async reset clears them immediately.
  // ptr_q already holds the current winner while in StSend.
  always_comb begin
    tx_new  = (state_q == StSend);
    gnt     = tx_new ? (ptr_q ? 2'b10 : 2'b01) : 2'b00;
    link_up = (state_q == StIdle) || (state_q == StSend) || (state_q == StHold);
    tx_data = tx_data_q;
  end

endmodule

// File: tb/tb_avr_link_arbiter.sv
// Testbench for avr_link_arbiter: directed bring-up/arbitration scenarios followed by random
// traffic, all compared against a reference model built from link-up and grant-spacing rules.
module tb_avr_link_arbiter;

  localparam int unsigned S = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cclk_ready;
  logic [1:0] req;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic       tx_busy;
  logic [1:0] gnt;
  logic [7:0] tx_data;
  logic       tx_new;
  logic       link_up;

  avr_link_arbiter #(
    .SETTLE_CYCLES(S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cclk_ready(cclk_ready),
    .req       (req),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .tx_busy   (tx_busy),
    .gnt       (gnt),
    .tx_data   (tx_data),
    .tx_new    (tx_new),
    .link_up   (link_up)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: link is up once cclk_ready has been sampled high on S+1 consecutive
  // edges; grants need the link up, no busy, a request, and >= 3 edges since the last grant.
  int         m_run;
  int         m_since;
  bit         m_ptr;
  logic [7:0] m_data;
  bit         m_new;
  logic [1:0] m_gnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run   = 0;
    m_since = 3;
    m_ptr   = 1'b1;
    m_data  = 8'h00;
    m_new   = 1'b0;
    m_gnt   = 2'b00;
  endtask

  task automatic model_edge();
    bit up;
    bit grant;
    bit w;
    up    = (m_run >= int'(S) + 1);
    grant = cclk_ready && up && (m_since >= 3) && !tx_busy && (req != 2'b00);
    if (!cclk_ready) m_run = 0;
    else if (m_run < int'(S) + 1) m_run++;
    if (grant) m_since = 1;
    else if (m_since < 3) m_since++;
    m_new = grant;
    m_gnt = 2'b00;
    if (grant) begin
      w      = (req == 2'b11) ? !m_ptr : req[1];
      m_ptr  = w;
      m_data = w ? req_data1 : req_data0;
      m_gnt  = w ? 2'b10 : 2'b01;
    end
  endtask

  // One clock: model steps with the DUT edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("tx_new", tx_new, m_new);
    check_eq("gnt", gnt, m_gnt);
    check_eq("tx_data", tx_data, m_data);
    check_eq("link_up", link_up, (m_run >= int'(S) + 1));
  endtask

  int         k;
  int         strobes;
  logic [1:0] seen_gnt [4];
  logic [7:0] seen_data [4];

  initial begin
    rst_n      = 1'b0;
    cclk_ready = 1'b1;
    req        = 2'b00;
    req_data0  = 8'h00;
    req_data1  = 8'h00;
    tx_busy    = 1'b0;
    model_reset();

    // Reset: everything quiet, even across clock edges.
    #1;
    check_eq("rst_tx_new", tx_new, 0);
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_link_up", link_up, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_hold_link_up", link_up, 0);
    check_eq("rst_hold_tx_new", tx_new, 0);
    rst_n = 1'b1;

    // Bring-up: first edge enters settle, link up S edges later.
    cycle();
    k = 0;
    for (int i = 0; i < 3 * S && !link_up; i++) begin
      cycle();
      k++;
    end
    check_eq("bringup_latency", k, S);

    // Contention: strict alternation starting with requester 0.
    req       = 2'b11;
    req_data0 = 8'h11;
    req_data1 = 8'h22;
    strobes   = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (tx_new && strobes < 4) begin
        seen_gnt[strobes]  = gnt;
        seen_data[strobes] = tx_data;
        strobes++;
      end
    end
    check_eq("cont_count", strobes, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq("cont_gnt", seen_gnt[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      check_eq("cont_data", seen_data[i], (i % 2 == 0) ? 8'h11 : 8'h22);
    end

    // Single requester: one strobe every 3 cycles.
    req       = 2'b01;
    req_data0 = 8'hA5;
    strobes   = 0;
    for (int i = 0; i < 9; i++) begin
      cycle();
      if (tx_new) begin
        strobes++;
        check_eq("single_data", tx_data, 8'hA5);
        check_eq("single_gnt", gnt, 2'b01);
      end
    end
    check_eq("single_count", strobes, 3);

    // Busy stall, then a grant the cycle after busy falls.
    req       = 2'b10;
    req_data1 = 8'h3C;
    tx_busy   = 1'b1;
    strobes   = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (tx_new) strobes++;
    end
    check_eq("busy_no_strobe", strobes, 0);
    tx_busy = 1'b0;
    cycle();
    check_eq("busy_release_tx_new", tx_new, 1);
    check_eq("busy_release_gnt", gnt, 2'b10);
    check_eq("busy_release_data", tx_data, 8'h3C);

    // Abort: drop cclk_ready during the hold cycle.
    req = 2'b00;
    repeat (3) cycle();
    req       = 2'b01;
    req_data0 = 8'h5A;
    cycle();
    check_eq("abort_send", tx_new, 1);
    req = 2'b00;
    cycle();
    cclk_ready = 1'b0;
    cycle();
    check_eq("abort_link_down", link_up, 0);
    cclk_ready = 1'b1;
    req        = 2'b01;
    strobes    = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (tx_new || link_up) strobes++;
    end
    check_eq("abort_quiet", strobes, 0);

    // Settle glitch: the high run above (5 cycles) is interrupted for one cycle.
    req        = 2'b00;
    cclk_ready = 1'b0;
    cycle();
    cclk_ready = 1'b1;
    cycle();
    k = 0;
    for (int i = 0; i < 3 * S && !link_up; i++) begin
      cycle();
      k++;
    end
    check_eq("glitch_latency", k, S);

    // Async reset in the middle of a send strobe.
    req       = 2'b10;
    req_data1 = 8'hC3;
    cycle();
    check_eq("mid_send_tx_new", tx_new, 1);
    rst_n = 1'b0;
    #1;
    check_eq("async_tx_new", tx_new, 0);
    check_eq("async_gnt", gnt, 0);
    check_eq("async_link_up", link_up, 0);
    check_eq("async_tx_data", tx_data, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic with occasional cclk loss.
    strobes = 0;
    for (int i = 0; i < 2000; i++) begin
      cclk_ready = ($urandom_range(0, 99) >= 2);
      tx_busy    = ($urandom_range(0, 3) == 0);
      req        = 2'($urandom_range(0, 3));
      req_data0  = 8'($urandom);
      req_data1  = 8'($urandom);
      cycle();
      if (tx_new) strobes++;
    end
    check_eq("rand_activity", (strobes > 50), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
